// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter, LSB first, valid/ready input, zero-gap back-to-back frames
// Optional runtime parity compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           parity_mode,
  output logic                 tx,
  output logic                 busy,
  output logic                 bit_tick,
  output logic                 frame_done
);

  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW = $clog2(MAX_BITS + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tx_q;
  logic                 tx_lvl;
  logic                 accept;

`ifdef UART_TX_PARITY_EN
  logic par_en;
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else if (accept) begin
      par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit <= (^in_data) ^ (parity_mode == 2'b01);
    end
  end
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  assign busy       = (state != IDLE);
  assign bit_tick   = busy && (baud_cnt == BAUD_LAST);
  assign frame_done = bit_tick && (state == STOP) && (bit_cnt == STOP_LAST);
  assign in_ready   = (state == IDLE) || frame_done;
  assign accept     = in_valid && in_ready;
  assign tx         = tx_q;

  always_comb begin
    state_n = state;
    tx_lvl  = 1'b1;
    case (state)
      IDLE: begin
        tx_lvl = 1'b1;
        if (accept) state_n = START;
      end
      START: begin
        tx_lvl = 1'b0;
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        tx_lvl = shift[0];
        if (bit_tick && (bit_cnt == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_n = par_en ? PARITY : STOP;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_lvl = par_bit;
        if (bit_tick) state_n = STOP;
      end
`endif
      STOP: begin
        tx_lvl = 1'b1;
        if (frame_done) state_n = accept ? START : IDLE;
      end
      default: begin
        tx_lvl  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // tx is the registered line level of the current state, so it trails state by one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_n;
      tx_q  <= tx_lvl;

      if (accept || (state == IDLE) || bit_tick) baud_cnt <= '0;
      else                                       baud_cnt <= baud_cnt + 1'b1;

      if (state_n != state) bit_cnt <= '0;
      else if (bit_tick)    bit_cnt <= bit_cnt + 1'b1;

      if (accept)                            shift <= in_data;
      else if (bit_tick && (state == DATA))  shift <= shift >> 1;
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the DE10 serial link. It serialises one data word per frame, LSB first, with a configurable word length, stop-bit count and baud divisor, plus optional runtime-selected parity. It accepts words over a valid/ready handshake and supports back-to-back frames with no idle gap. It sits between the host-side command/data logic and the board TX pin, and carries its own baud counter.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, default 434: clk cycles per bit period (50 MHz / 115200); must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_BITS  word to transmit; sampled only on accept.
- `in_valid`  in  1  word available.
- `in_ready`  out  1  block can accept a word this cycle.
- `parity_mode`  in  2  00 = none, 01 = odd, 10 = even, 11 = none; sampled on accept.
- `tx`  out  1  serial line, idle high; registered output.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `bit_tick`  out  1  one-cycle pulse on the last clk of every bit period.
- `frame_done`  out  1  one-cycle pulse on the last clk of the final stop bit.

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge. On accept, the block latches `in_data` and `parity_mode`, computes the parity bit, and loads the shift register.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA → PARITY when parity is enabled; otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE, or STOP → START if a new word is accepted in the final cycle.
- Every state except IDLE lasts exactly CLKS_PER_BIT cycles per bit. DATA lasts DATA_BITS bit periods; STOP lasts STOP_BITS bit periods.
- Line levels per state: IDLE drives `tx` = 1; START drives 0; DATA drives `shift[0]`, shifting right on each `bit_tick`; PARITY drives the parity bit; STOP drives 1.
- Parity: even mode sends the XOR of the data bits; odd mode sends the inverse of that XOR.
- `in_ready` is high in IDLE, and also in the final cycle of the last stop bit (the cycle where `frame_done` = 1). This gives zero-gap back-to-back frames.
- `in_valid` deasserted while `in_ready` is high: no action, and the block stays in or returns to IDLE.
- The baud counter is 0..CLKS_PER_BIT-1. It is cleared in IDLE and on every accept, and it wraps on `bit_tick`.
- The bit counter counts data and stop bits. Its width is ceil(log2(max(DATA_BITS, STOP_BITS) + 1)).

## Timing
- Reset values (held while `rst` = 1 and in the cycle after release): `tx` = 1, `in_ready` = 1, `busy` = 0, `bit_tick` = 0, `frame_done` = 0, state = IDLE, all counters 0.
- Reset asserted mid-frame: the frame is abandoned. `tx` = 1 from the next edge; no `frame_done` pulse is generated.
- Latency: with accept at edge k, `tx` falls to 0 after edge k+1. The start bit then lasts CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 if parity is active, else 0.
- `frame_done` and `bit_tick` are coincident on the final cycle.
- Back-to-back accept at `frame_done`: the next start bit begins immediately after the current stop bit, with no extra idle cycle.
- `in_data` and `parity_mode` changes while `busy` = 1 do not affect the current frame.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state, parity logic and `parity_mode` decode are compiled in, with behaviour as above.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are removed. `parity_mode` remains a port but is ignored, and every frame behaves as parity none (P = 0).

## Test plan
- Reset: hold `rst` for 3 cycles mid-frame → `tx` = 1, `in_ready` = 1, `busy` = 0, no `frame_done`, on the cycle after the reset edge.
- DATA_BITS=8, CLKS_PER_BIT=4, parity none, send 0xA5 → `tx` = 0 then 1,0,1,0,0,1,0,1 then 1, each level held 4 cycles; `frame_done` at cycle 40 after accept.
- Same settings, parity even then odd, send 0xA5 → parity bit 0 (even) and 1 (odd) inserted before stop; frame length 44 cycles.
- Back-to-back: `in_valid` held high with 0x00 then 0xFF, STOP_BITS=2 → second start bit immediately follows the 2nd stop bit with no idle cycle; exactly 2 `frame_done` pulses.
- DATA_BITS=5, send 0x1F with upper input bits garbage → exactly 5 data bits of 1, then stop; bits above the word width never appear on `tx`.
- Macro undefined, parity_mode=10 → frame identical to the parity-none case, 40 cycles at CLKS_PER_BIT=4.
